// File: rtl/pair_match_arbiter.sv
// rtl/pair_match_arbiter.sv - round-robin shared 5-bit pairwise-equality matrix and popcount engine
// One requester is served at a time: the matrix is registered on grant, then popcounted one row per cycle.
module pair_match_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*5-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [24:0]            res_matrix,
  output logic [4:0]             res_count,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            any_valid;
  logic [4:0]      win_vec;
  logic [24:0]     mat_nxt;
  logic [2:0]      row;
  logic [4:0]      acc;
  logic [4:0]      row_bits;
  logic [2:0]      row_pc;
  logic [4:0]      acc_nxt;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    logic [ID_W:0] idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_vec = '0;
    for (int r = 0; r < NUM_REQ; r++)
      if (winner == ID_W'(r))
        win_vec = req_data[5*r +: 5];
  end

  // Vector bit 4 holds x0, so x_i lives at win_vec[4-i].
  always_comb begin
    mat_nxt = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        mat_nxt[24-(5*i+j)] = ~(win_vec[4-i] ^ win_vec[4-j]);
  end

  always_comb begin
    row_bits = '0;
    for (int r = 0; r < 5; r++)
      if (row == 3'(r))
        row_bits = res_matrix[24-5*r -: 5];
    row_pc  = {2'b0, row_bits[0]} + {2'b0, row_bits[1]} + {2'b0, row_bits[2]}
            + {2'b0, row_bits[3]} + {2'b0, row_bits[4]};
    acc_nxt = acc + {2'b0, row_pc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          state_nxt         = COUNT;
        end
      end
      COUNT: begin
        if (row == 3'd4)
          state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      row        <= '0;
      acc        <= '0;
      res_id     <= '0;
      res_matrix <= '0;
      res_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            res_matrix <= mat_nxt;
            res_id     <= winner;
            ptr        <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
            acc        <= '0;
            row        <= '0;
          end
        end
        COUNT: begin
          acc <= acc_nxt;
          row <= row + 3'd1;
          if (row == 3'd4)
            res_count <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
